sw_array_feeder: RTL and testbench
==================================

# sw_array_feeder

Transmit-side controller for the Smith-Waterman systolic array. It accepts a short read and a reference stream over valid/ready handshakes. It shifts the read into the PE chain with `store_S`, then streams reference symbols with `init` asserted. It drains the chain and pulses `done`. It sits between the host-facing symbol FIFOs and PE 0; the left-boundary V/F inputs of PE 0 are tied to zero at the array top level, not here.

## Interface
Parameters:
- `NUM_PE`, 6: number of PEs in the chain; also the fixed read length.
- `CNT_WIDTH`, 8: width of internal counters; must satisfy 2^CNT_WIDTH > NUM_PE.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a job; sampled only in IDLE.
- `stall_in`  in  1  downstream backpressure from the result collector.
- `read_sym`  in  2  read symbol (A=00, C=01, G=10, T=11).
- `read_valid`  in  1  read_sym valid.
- `read_ready`  out  1  feeder accepts read_sym this cycle.
- `ref_sym`  in  2  reference symbol.
- `ref_valid`  in  1  ref_sym valid.
- `ref_last`  in  1  marks the final reference symbol.
- `ref_ready`  out  1  feeder accepts ref_sym this cycle.
- `S_out`  out  2  to PE 0 `S_in`.
- `store_S_out`  out  1  to PE 0 `store_S_in`.
- `T_out`  out  2  to PE 0 `T_in`.
- `init_out`  out  1  to PE 0 `init_in`.
- `pe_stall`  out  1  to every PE's `stall`.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse at the end of FLUSH.

## Operation
- **States:** IDLE, LOAD, SEND_S, STREAM, FLUSH.
- **IDLE:**
  - `start` moves to LOAD; `start` in any other state is ignored.
  - Outputs driven to 0.
- **LOAD:**
  - `read_ready` = !`stall_in`.
  - Each handshake writes the symbol into buffer slot `wr_cnt` and increments `wr_cnt`.
  - After NUM_PE accepts, go to SEND_S.
- **SEND_S:**
  - NUM_PE cycles with `store_S_out`=1.
  - `S_out` = buffer[NUM_PE-1-k] on send cycle k, so the first read symbol lands in PE 0 and the last in PE NUM_PE-1.
  - `init_out`=0. Then go to STREAM.
- **STREAM:**
  - `ref_ready` = !`stall_in`.
  - On each handshake, the next cycle drives `T_out`=ref_sym and `init_out`=1.
  - If `ref_valid`=0, `T_out`/`init_out` hold and `pe_stall`=1; no bubble is injected.
  - Accepting a symbol with `ref_last`=1 moves to FLUSH.
- **FLUSH:**
  - NUM_PE cycles with `T_out`=00 and `init_out`=0, to drain the last column.
  - `done`=1 on the final FLUSH cycle, then go to IDLE.
- **Stall and pe_stall:**
  - `pe_stall` = `stall_in` | (STREAM & !`ref_valid`), combinational.
  - While `stall_in`=1, all registers, counters and outputs hold, and both ready outputs are 0.
- **Short reads:** none. A job always carries exactly NUM_PE read symbols.

## Timing
- **Reset:** state=IDLE, counters=0, buffer contents don't-care. `S_out`, `store_S_out`, `T_out`, `init_out`, `busy`, `done`, `read_ready`, `ref_ready` are 0. `pe_stall` equals `stall_in`.
- **Registered outputs:** `S_out`, `store_S_out`, `T_out`, `init_out`, `done`, `busy`.
- **Combinational outputs:** `read_ready`, `ref_ready`, `pe_stall` (from state, `stall_in` and `ref_valid`).
- **Start:** `start` at cycle 0 gives `busy`=1 and `read_ready`=1 at cycle 1.
- **SEND_S:** the last LOAD accept at cycle n gives `store_S_out`=1 at cycles n+1 … n+NUM_PE.
- **Reference latency:** 1 cycle from handshake to `T_out`/`init_out`.
- **Unstalled job length:** 1 + NUM_PE + NUM_PE + R + NUM_PE cycles from `start` to `done`, where R is the reference length.
- **Stall timing:** `stall_in` asserted in a cycle blocks that cycle's handshake and freezes state for the next edge.
- **Reset mid-operation:** returns to IDLE next edge. No `done` is emitted, and buffered symbols are discarded.
- **`ref_last` on a single-symbol reference:** legal, with R=1.

## Structure
- **Shared package `sw_pkg`:**
  - Symbol encoding constants `SYM_A/C/G/T`.
  - 2-bit symbol typedef.
  - Feeder state enum.
  - Shared with the PE and the result collector.
- **Sub-module `sw_read_buffer`:**
  - NUM_PE x 2-bit register file.
  - Write port with `wr_en`/`wr_addr`; combinational read at `rd_addr`.
  - The feeder computes reverse addressing.

## Test plan
- **Basic load, NUM_PE=6:** read 00,01,00,01,11,00, then `start`. Require `S_out` sequence 00,11,01,00,01,00 with `store_S_out`=1 for exactly 6 consecutive cycles, and `init_out`=0 throughout.
- **Reference stream:** 00,01,00,10,00,01,11,00 with `ref_last` on the 8th, `ref_valid` continuous. Require `T_out` to match 1 cycle after each accept with `init_out`=1. Then 6 FLUSH cycles with `init_out`=0, `done`=1 exactly once, and `busy`=0 the cycle after.
- **Reference gaps:** drop `ref_valid` for 3 cycles mid-stream. Require `pe_stall`=1 for those 3 cycles and `T_out` held. No duplicated or skipped symbols.
- **Backpressure:** `stall_in`=1 for 4 cycles during each of LOAD, SEND_S and FLUSH. Require readies=0, outputs frozen, and total job length +12 cycles vs. unstalled.
- **Start and reset:**
  - `start` pulsed during STREAM: ignored.
  - `rst` asserted during SEND_S: next cycle IDLE with all outputs 0.
  - A new job after reset completes correctly.
- **Minimum reference:** single reference symbol with `ref_last`=1. Require one `init_out` cycle, then FLUSH and `done`, with job length 20 cycles for NUM_PE=6.

Source files
------------

// File: rtl/sw_pkg.sv
// Shared Smith-Waterman definitions: symbol encoding and feeder state encoding.
// Imported by the feeder, the PEs and the result collector.
package sw_pkg;

    typedef logic [1:0] sym_t;

    localparam sym_t SYM_A = 2'b00;
    localparam sym_t SYM_C = 2'b01;
    localparam sym_t SYM_G = 2'b10;
    localparam sym_t SYM_T = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SEND_S = 3'd2,
        ST_STREAM = 3'd3,
        ST_FLUSH  = 3'd4
    } feeder_state_t;

endpackage

// File: rtl/sw_read_buffer.sv
// Small register file holding one read (NUM_PE symbols).
// Synchronous write, combinational read; the caller does any address reversal.
module sw_read_buffer
    import sw_pkg::*;
#(
    parameter int NUM_PE = 6,
    parameter int AW     = 8
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [1:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [1:0]    rd_data
);

    sym_t r_mem [NUM_PE];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_PE; i++) begin
            if (wr_en && (wr_addr == AW'(i))) begin
                r_mem[i] <= wr_data;
            end
        end
    end

    // Explicit decode keeps out-of-range addresses harmless (they read as A).
    always_comb begin
        rd_data = SYM_A;
        for (int i = 0; i < NUM_PE; i++) begin
            if (rd_addr == AW'(i)) begin
                rd_data = r_mem[i];
            end
        end
    end

endmodule

// File: rtl/sw_array_feeder.sv
// Feeds PE 0 of the systolic array: loads a read, shifts it in with store_S,
// streams reference symbols with init, then drains the chain and pulses done.
module sw_array_feeder
    import sw_pkg::*;
#(
    parameter int NUM_PE    = 6,
    parameter int CNT_WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stall_in,
    input  logic [1:0] read_sym,
    input  logic       read_valid,
    output logic       read_ready,
    input  logic [1:0] ref_sym,
    input  logic       ref_valid,
    input  logic       ref_last,
    output logic       ref_ready,
    output logic [1:0] S_out,
    output logic       store_S_out,
    output logic [1:0] T_out,
    output logic       init_out,
    output logic       pe_stall,
    output logic       busy,
    output logic       done
);

    localparam logic [CNT_WIDTH-1:0] C_LAST      = CNT_WIDTH'(NUM_PE - 1);
    localparam logic [CNT_WIDTH-1:0] C_FLUSH_END = CNT_WIDTH'(NUM_PE);
    localparam logic [CNT_WIDTH-1:0] C_ONE       = CNT_WIDTH'(1);

    feeder_state_t        r_state, w_state_next;
    logic [CNT_WIDTH-1:0] r_cnt, w_cnt_next;
    sym_t                 r_s, w_s_next;
    logic                 r_store, w_store_next;
    sym_t                 r_t, w_t_next;
    logic                 r_init, w_init_next;
    logic                 r_done, w_done_next;
    logic                 r_busy, w_busy_next;

    logic                 w_read_fire;
    logic                 w_ref_fire;
    logic [CNT_WIDTH-1:0] w_rd_addr;
    sym_t                 w_rd_data;

    assign read_ready  = (r_state == ST_LOAD) && !stall_in;
    assign ref_ready   = (r_state == ST_STREAM) && !stall_in;
    assign pe_stall    = stall_in || ((r_state == ST_STREAM) && !ref_valid);
    assign w_read_fire = read_ready && read_valid;
    assign w_ref_fire  = ref_ready && ref_valid;

    // Send cycle k already shows slot NUM_PE-1-k; this edge loads slot NUM_PE-2-k.
    assign w_rd_addr = (r_cnt < C_LAST) ? (C_LAST - r_cnt - C_ONE) : '0;

    sw_read_buffer #(
        .NUM_PE (NUM_PE),
        .AW     (CNT_WIDTH)
    ) u_read_buffer (
        .clk     (clk),
        .wr_en   (w_read_fire),
        .wr_addr (r_cnt),
        .wr_data (read_sym),
        .rd_addr (w_rd_addr),
        .rd_data (w_rd_data)
    );

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_s_next     = r_s;
        w_store_next = r_store;
        w_t_next     = r_t;
        w_init_next  = r_init;
        w_done_next  = r_done;
        w_busy_next  = r_busy;
        if (!stall_in) begin
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_state_next = ST_LOAD;
                        w_cnt_next   = '0;
                        w_busy_next  = 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (w_read_fire) begin
                        if (r_cnt == C_LAST) begin
                            // Last symbol is still being written, so bypass it.
                            w_state_next = ST_SEND_S;
                            w_cnt_next   = '0;
                            w_s_next     = read_sym;
                            w_store_next = 1'b1;
                        end else begin
                            w_cnt_next = r_cnt + C_ONE;
                        end
                    end
                end
                ST_SEND_S: begin
                    if (r_cnt == C_LAST) begin
                        w_state_next = ST_STREAM;
                        w_cnt_next   = '0;
                        w_s_next     = SYM_A;
                        w_store_next = 1'b0;
                    end else begin
                        w_s_next   = w_rd_data;
                        w_cnt_next = r_cnt + C_ONE;
                    end
                end
                ST_STREAM: begin
                    if (w_ref_fire) begin
                        w_t_next    = ref_sym;
                        w_init_next = 1'b1;
                        if (ref_last) begin
                            w_state_next = ST_FLUSH;
                            w_cnt_next   = '0;
                        end
                    end
                end
                ST_FLUSH: begin
                    // One extra cycle after the done pulse so busy drops right after it.
                    if (r_cnt == C_FLUSH_END) begin
                        w_state_next = ST_IDLE;
                        w_cnt_next   = '0;
                        w_done_next  = 1'b0;
                        w_busy_next  = 1'b0;
                    end else begin
                        w_t_next    = SYM_A;
                        w_init_next = 1'b0;
                        w_done_next = (r_cnt == C_LAST);
                        w_cnt_next  = r_cnt + C_ONE;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = '0;
                    w_busy_next  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_s     <= SYM_A;
            r_store <= 1'b0;
            r_t     <= SYM_A;
            r_init  <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_s     <= w_s_next;
            r_store <= w_store_next;
            r_t     <= w_t_next;
            r_init  <= w_init_next;
            r_done  <= w_done_next;
            r_busy  <= w_busy_next;
        end
    end

    assign S_out       = r_s;
    assign store_S_out = r_store;
    assign T_out       = r_t;
    assign init_out    = r_init;
    assign done        = r_done;
    assign busy        = r_busy;

endmodule

// File: tb/tb_sw_array_feeder.sv
// Directed bench for sw_array_feeder: a per-cycle vector table for a full job
// with a reference gap, plus sequences for backpressure, reset and a 1-symbol job.
module tb_sw_array_feeder;

    localparam int NUM_PE = 6;
    localparam int NROWS  = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stall_in;
    logic [1:0] read_sym;
    logic       read_valid;
    logic       read_ready;
    logic [1:0] ref_sym;
    logic       ref_valid;
    logic       ref_last;
    logic       ref_ready;
    logic [1:0] S_out;
    logic       store_S_out;
    logic [1:0] T_out;
    logic       init_out;
    logic       pe_stall;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sw_array_feeder #(
        .NUM_PE    (NUM_PE),
        .CNT_WIDTH (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stall_in    (stall_in),
        .read_sym    (read_sym),
        .read_valid  (read_valid),
        .read_ready  (read_ready),
        .ref_sym     (ref_sym),
        .ref_valid   (ref_valid),
        .ref_last    (ref_last),
        .ref_ready   (ref_ready),
        .S_out       (S_out),
        .store_S_out (store_S_out),
        .T_out       (T_out),
        .init_out    (init_out),
        .pe_stall    (pe_stall),
        .busy        (busy),
        .done        (done)
    );

    typedef struct {
        logic       start;
        logic       rv;
        logic [1:0] rs;
        logic       fv;
        logic [1:0] fs;
        logic       fl;
        logic       e_rr;
        logic       e_fr;
        logic [1:0] e_s;
        logic       e_st;
        logic [1:0] e_t;
        logic       e_init;
        logic       e_pes;
        logic       e_busy;
        logic       e_done;
    } vec_t;

    vec_t       v [NROWS];
    logic [1:0] t1_read [6];
    logic [1:0] t1_exp_s [6];
    logic [1:0] t1_ref [8];
    int         t1_ref_row [8];

    logic [1:0] job_read [6];
    logic [1:0] job_ref [8];
    logic       stall_at [64];
    int         start_extra;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] obs();
        return {read_ready, ref_ready, S_out, store_S_out, T_out, init_out, pe_stall, busy, done};
    endfunction

    task automatic idle_inputs();
        start      = 1'b0;
        stall_in   = 1'b0;
        read_valid = 1'b0;
        read_sym   = 2'b00;
        ref_valid  = 1'b0;
        ref_sym    = 2'b00;
        ref_last   = 1'b0;
    endtask

    // Runs one job with a generic handshake driver; stall cycles and an extra
    // start pulse come from stall_at/start_extra, cycle 0 being the start cycle.
    task automatic run_job(input string tag, input int r_len, input int exp_len);
        int         rd_i = 0;
        int         rf_i = 0;
        int         s_k = 0;
        int         done_cnt = 0;
        int         done_cyc = -1;
        logic       prev_stall = 1'b0;
        logic       prev_fire = 1'b0;
        logic [1:0] prev_sym = 2'b00;
        logic [7:0] prev_regs = '0;
        logic [7:0] regs;
        for (int c = 0; c < exp_len + 8; c++) begin
            @(posedge clk);
            #1;
            start      = (c == 0) || (c == start_extra);
            stall_in   = stall_at[c];
            read_valid = (rd_i < NUM_PE);
            read_sym   = job_read[(rd_i < NUM_PE) ? rd_i : 0];
            ref_valid  = (rf_i < r_len);
            ref_sym    = job_ref[(rf_i < r_len) ? rf_i : 0];
            ref_last   = (rf_i == r_len - 1);
            #1;
            regs = {S_out, store_S_out, T_out, init_out, done, busy};
            if (stall_in)
                check({tag, " stall readies/pe_stall"}, 32'({read_ready, ref_ready, pe_stall}), 32'(3'b001));
            if (prev_stall)
                check({tag, " frozen outputs"}, 32'(regs), 32'(prev_regs));
            if (store_S_out && !prev_stall) begin
                if (s_k < NUM_PE)
                    check($sformatf("%s S_out[%0d]", tag, s_k), 32'({init_out, S_out}), 32'({1'b0, job_read[NUM_PE-1-s_k]}));
                else
                    check({tag, " extra store_S"}, 32'(s_k), 32'(NUM_PE - 1));
                s_k++;
            end
            if (prev_fire)
                check($sformatf("%s T_out after accept %0d", tag, rf_i - 1), 32'({init_out, T_out}), 32'({1'b1, prev_sym}));
            if (done) begin
                done_cnt++;
                done_cyc = c;
            end
            if ((done_cyc >= 0) && (c == done_cyc + 1)) begin
                check({tag, " busy after done"}, 32'({busy, done}), 32'(0));
                break;
            end
            prev_fire = ref_valid && ref_ready;
            prev_sym  = ref_sym;
            if (read_valid && read_ready) rd_i++;
            if (prev_fire) rf_i++;
            prev_regs  = regs;
            prev_stall = stall_in;
        end
        idle_inputs();
        check({tag, " done count"}, 32'(done_cnt), 32'(1));
        check({tag, " done cycle"}, 32'(done_cyc), 32'(exp_len));
        check({tag, " store_S count"}, 32'(s_k), 32'(NUM_PE));
        check({tag, " refs accepted"}, 32'(rf_i), 32'(r_len));
    endtask

    initial begin
        idle_inputs();
        rst         = 1'b1;
        start_extra = -1;
        for (int i = 0; i < 64; i++) stall_at[i] = 1'b0;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("reset outputs", 32'(obs()), 32'(0));
        stall_in = 1'b1;
        #1;
        check("reset pe_stall follows stall_in", 32'(obs()), 32'(11'b00000000100));
        stall_in = 1'b0;

        // ---------------- table: full job, 3-cycle reference gap ----------------
        t1_read    = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b11, 2'b00};
        t1_exp_s   = '{2'b00, 2'b11, 2'b01, 2'b00, 2'b01, 2'b00};
        t1_ref     = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b11, 2'b00};
        t1_ref_row = '{13, 14, 15, 16, 20, 21, 22, 23};
        for (int r = 0; r < NROWS; r++) v[r] = '{default: '0};
        v[0].start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            v[1+i].rv   = 1'b1;
            v[1+i].rs   = t1_read[i];
            v[1+i].e_rr = 1'b1;
        end
        for (int k = 0; k < 6; k++) begin
            v[7+k].e_st = 1'b1;
            v[7+k].e_s  = t1_exp_s[k];
        end
        for (int r = 1; r <= 30; r++) v[r].e_busy = 1'b1;
        for (int r = 13; r <= 23; r++) begin
            v[r].e_fr  = 1'b1;
            v[r].e_pes = 1'b1;
        end
        for (int j = 0; j < 8; j++) begin
            v[t1_ref_row[j]].fv       = 1'b1;
            v[t1_ref_row[j]].fs       = t1_ref[j];
            v[t1_ref_row[j]].fl       = (j == 7);
            v[t1_ref_row[j]].e_pes    = 1'b0;
            v[t1_ref_row[j]+1].e_t    = t1_ref[j];
            v[t1_ref_row[j]+1].e_init = 1'b1;
        end
        for (int r = 18; r <= 20; r++) begin
            v[r].e_t    = t1_ref[3];
            v[r].e_init = 1'b1;
        end
        v[30].e_done = 1'b1;

        for (int r = 0; r < NROWS; r++) begin
            @(posedge clk);
            #1;
            start      = v[r].start;
            stall_in   = 1'b0;
            read_valid = v[r].rv;
            read_sym   = v[r].rs;
            ref_valid  = v[r].fv;
            ref_sym    = v[r].fs;
            ref_last   = v[r].fl;
            #1;
            check($sformatf("vec row %0d", r), 32'(obs()),
                  32'({v[r].e_rr, v[r].e_fr, v[r].e_s, v[r].e_st, v[r].e_t,
                       v[r].e_init, v[r].e_pes, v[r].e_busy, v[r].e_done}));
        end
        idle_inputs();

        // ---------------- backpressure in LOAD, SEND_S, FLUSH; start ignored in STREAM ----------------
        job_read = '{2'b11, 2'b10, 2'b01, 2'b00, 2'b01, 2'b10};
        job_ref  = '{2'b10, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00};
        for (int i = 3; i <= 6; i++) stall_at[i] = 1'b1;
        for (int i = 12; i <= 15; i++) stall_at[i] = 1'b1;
        for (int i = 27; i <= 30; i++) stall_at[i] = 1'b1;
        start_extra = 22;
        run_job("bp", 4, 19 + 4 + 12);
        for (int i = 0; i < 64; i++) stall_at[i] = 1'b0;
        start_extra = -1;

        // ---------------- reset during SEND_S ----------------
        job_read = '{2'b01, 2'b01, 2'b10, 2'b11, 2'b00, 2'b10};
        for (int c = 0; c <= 8; c++) begin
            @(posedge clk);
            #1;
            start      = (c == 0);
            read_valid = (c >= 1) && (c <= 6);
            read_sym   = job_read[((c >= 1) && (c <= 6)) ? c - 1 : 0];
            rst        = (c == 8);
            #1;
            if (c == 8) check("rst: in SEND_S before rst", 32'({store_S_out, busy}), 32'(2'b11));
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_inputs();
        #1;
        check("rst: outputs after rst", 32'(obs()), 32'(0));

        // ---------------- new job after reset, single reference symbol ----------------
        job_read = '{2'b10, 2'b00, 2'b11, 2'b01, 2'b11, 2'b10};
        job_ref  = '{2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        run_job("minref", 1, 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
